// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Issue stage for the combinational alu8bit. Accepts one
//                operation per valid/ready handshake, registers the operands
//                into the ALU, and captures the result with carry/borrow,
//                zero and divide-by-zero flags into a show-ahead result FIFO.
//                An accumulator holds the last good result for chaining.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [3:0] in_op,
    input  logic       in_use_acc,

    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,

    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_zero,
    output logic       res_err,

    output logic [7:0] acc
);

    // Pointer and occupancy widths; the count needs one extra state for full.
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    localparam logic [3:0] c_OP_ADD = 4'h0;
    localparam logic [3:0] c_OP_SUB = 4'h1;
    localparam logic [3:0] c_OP_DIV = 4'h3;

    // Entry layout: {err, zero, carry, data}
    localparam int c_ENTRY_W = 11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_ENTRY_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_div_zero;
    logic [7:0]             w_data;
    logic                   w_carry;
    logic                   w_zero;
    logic [c_ENTRY_W-1:0]   w_entry;
    logic [c_ENTRY_W-1:0]   w_head;

    // A FIFO slot must be free before accepting, so the EXEC push never overflows.
    assign in_ready = (r_state == S_IDLE) && (r_count < c_FULL);
    assign w_accept = in_valid && in_ready;
    assign w_push   = (r_state == S_EXEC);
    assign w_pop    = res_valid && res_ready;

    // Result formation from the ALU response for the operation in flight.
    always_comb begin
        w_div_zero = (alu_op == c_OP_DIV) && (alu_b == 8'h00);
        w_data     = alu_out;
        w_carry    = 1'b0;
        if (w_div_zero) begin
            w_data = 8'hFF;
        end else if (alu_op == c_OP_ADD) begin
            w_carry = alu_carry;
        end else if (alu_op == c_OP_SUB) begin
            // The ALU carry is always that of a+b, so the borrow is derived here.
            w_carry = (alu_a < alu_b);
        end
        w_zero  = !w_div_zero && (w_data == 8'h00);
        w_entry = {w_div_zero, w_zero, w_carry, w_data};
    end

    // Issue FSM: operand capture on accept, accumulator update on EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            alu_a   <= 8'h00;
            alu_b   <= 8'h00;
            alu_op  <= 4'h0;
            acc     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_a   <= in_use_acc ? acc : in_a;
                        alu_b   <= in_b;
                        alu_op  <= in_op;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A divide by zero leaves the accumulator untouched.
                    if (!w_div_zero) begin
                        acc <= w_data;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Show-ahead head; masked to zero while the FIFO is empty.
    assign res_valid = (r_count != '0);
    assign w_head    = res_valid ? r_mem[r_rd_ptr] : '0;
    assign res_data  = w_head[7:0];
    assign res_carry = w_head[8];
    assign res_zero  = w_head[9];
    assign res_err   = w_head[10];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Directed self-checking bench for alu_issue_stage with a
//                small behavioural alu8bit closing the loop.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic [3:0] in_op = 4'h0;
    logic       in_use_acc = 1'b0;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_carry, res_zero, res_err;
    logic [7:0] acc;

    int checks = 0;
    int errors = 0;

    alu_issue_stage #(.DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry),
        .res_zero(res_zero), .res_err(res_err),
        .acc(acc)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; divide by zero returns 00 so the stage's FF forcing is visible.
    logic [15:0] m_prod;
    logic [8:0]  m_sum;
    assign m_prod    = 16'(alu_a) * 16'(alu_b);
    assign m_sum     = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_carry = m_sum[8];
    always_comb begin
        alu_out = 8'h00;
        case (alu_op)
            4'h0: alu_out = m_sum[7:0];
            4'h1: alu_out = alu_a - alu_b;
            4'h2: alu_out = m_prod[7:0];
            4'h3: alu_out = (alu_b != 8'h00) ? alu_a / alu_b : 8'h00;
            4'h4: alu_out = alu_a << 1;
            4'h5: alu_out = alu_a >> 1;
            4'h6: alu_out = {alu_a[6:0], alu_a[7]};
            4'h7: alu_out = {alu_a[0], alu_a[7:1]};
            4'h8: alu_out = alu_a & alu_b;
            4'h9: alu_out = alu_a | alu_b;
            4'hA: alu_out = alu_a ^ alu_b;
            4'hB: alu_out = ~(alu_a | alu_b);
            4'hC: alu_out = ~(alu_a & alu_b);
            4'hD: alu_out = ~(alu_a ^ alu_b);
            4'hE: alu_out = {7'd0, alu_a > alu_b};
            4'hF: alu_out = {7'd0, alu_a == alu_b};
            default: alu_out = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, take it on the next edge, then let EXEC push it.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, input logic use_acc);
        in_a = a; in_b = b; in_op = op; in_use_acc = use_acc; in_valid = 1'b1;
        chk("ready_before_accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; in_use_acc = 1'b0;
        chk("exec_in_ready_low", in_ready, 1'b0);
        tick();
    endtask

    task automatic check_head(input string tag, input logic [7:0] d, input logic c,
                              input logic z, input logic e);
        chk({tag, "_valid"}, res_valid, 1'b1);
        chk({tag, "_data"},  res_data,  d);
        chk({tag, "_carry"}, res_carry, c);
        chk({tag, "_zero"},  res_zero,  z);
        chk({tag, "_err"},   res_err,   e);
    endtask

    task automatic pop();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 8'h00);
        chk("rst_acc", acc, 8'h00);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_op", alu_op, 4'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // ADD F0+20 with latency checks
        in_a = 8'hF0; in_b = 8'h20; in_op = 4'h0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_alu_a", alu_a, 8'hF0);
        chk("add_alu_b", alu_b, 8'h20);
        chk("add_no_result_yet", res_valid, 1'b0);
        tick();
        check_head("add", 8'h10, 1'b1, 1'b0, 1'b0);
        chk("add_acc", acc, 8'h10);
        chk("add_ready_again", in_ready, 1'b1);
        pop();
        chk("add_popped", res_valid, 1'b0);

        // SUB with borrow, then chained ADD from the accumulator
        issue(8'h05, 8'h07, 4'h1, 1'b0);
        check_head("sub", 8'hFE, 1'b1, 1'b0, 1'b0);
        chk("sub_acc", acc, 8'hFE);
        pop();
        in_a = 8'h55; in_b = 8'h02; in_op = 4'h0; in_use_acc = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_use_acc = 1'b0;
        chk("chain_alu_a", alu_a, 8'hFE);
        tick();
        check_head("chain", 8'h00, 1'b1, 1'b1, 1'b0);
        chk("chain_acc", acc, 8'h00);
        pop();

        // Divide by zero, then a good divide
        issue(8'h12, 8'h00, 4'h3, 1'b0);
        check_head("div0", 8'hFF, 1'b0, 1'b0, 1'b1);
        chk("div0_acc_kept", acc, 8'h00);
        pop();
        issue(8'h12, 8'h03, 4'h3, 1'b0);
        check_head("div", 8'h06, 1'b0, 1'b0, 1'b0);
        chk("div_acc", acc, 8'h06);
        pop();

        // Backpressure with two FIFO entries
        issue(8'h0F, 8'hFF, 4'hA, 1'b0);
        issue(8'h0F, 8'h3C, 4'h8, 1'b0);
        chk("bp_full_not_ready", in_ready, 1'b0);
        in_a = 8'h01; in_b = 8'h02; in_op = 4'h9; in_valid = 1'b1;
        tick();
        chk("bp_or_held_off", in_ready, 1'b0);
        chk("bp_alu_op_kept", alu_op, 4'h8);
        check_head("bp_head0", 8'hF0, 1'b0, 1'b0, 1'b0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp_ready_after_pop", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_or_accepted_op", alu_op, 4'h9);
        tick();
        check_head("bp_head1", 8'h0C, 1'b0, 1'b0, 1'b0);
        pop();
        check_head("bp_head2", 8'h03, 1'b0, 1'b0, 1'b0);
        chk("bp_acc", acc, 8'h03);
        pop();
        chk("bp_drained", res_valid, 1'b0);

        // Reset during EXEC discards the in-flight MUL
        in_a = 8'h03; in_b = 8'h05; in_op = 4'h2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mul_alu_op", alu_op, 4'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_res_valid", res_valid, 1'b0);
        chk("mrst_acc", acc, 8'h00);
        chk("mrst_alu_a", alu_a, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mrst_no_result", res_valid, 1'b0);
        chk("mrst_acc_zero", acc, 8'h00);

        // First op after reset release
        issue(8'h01, 8'h02, 4'h0, 1'b0);
        check_head("post_rst", 8'h03, 1'b0, 1'b0, 1'b0);
        chk("post_rst_acc", acc, 8'h03);
        pop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Sequential front end for the combinational `alu8bit`. It accepts one operation at a time over a valid/ready handshake, registers the operands, and drives them into the ALU. It captures the ALU result with carry/borrow, zero and error flags into a small result FIFO, and keeps an accumulator so back-to-back ops can chain on the previous result without a round trip through the requester.

## Interface
Parameters:
- `DEPTH`, default 2: result FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operation request valid.
- `in_ready`  out  1  stage can accept a request this cycle.
- `in_a`  in  8  operand A.
- `in_b`  in  8  operand B.
- `in_op`  in  4  opcode, ALU encoding:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR, 6 ROL, 7 ROR
  - 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR, E GT, F EQ
- `in_use_acc`  in  1  replace operand A with the accumulator.
- `alu_a`, `alu_b`  out  8 each  registered operands driven to the ALU.
- `alu_op`  out  4  registered opcode driven to the ALU.
- `alu_out`  in  8  ALU result.
- `alu_carry`  in  1  ALU carry; always the carry of a+b, whatever the opcode.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  consumer takes the head this cycle.
- `res_data`  out  8  head result.
- `res_carry`  out  1  head carry/borrow.
- `res_zero`  out  1  head result == 0.
- `res_err`  out  1  head was a divide by zero.
- `acc`  out  8  accumulator value.

## Operation
State machine, two states:
- **IDLE**
  - `in_ready` = 1 when the FIFO count < `DEPTH`.
  - On accept (`in_valid && in_ready`):
    - `alu_a` ← (`in_use_acc` ? `acc` : `in_a`).
    - `alu_b` ← `in_b`; `alu_op` ← `in_op`.
    - Go to EXEC.
- **EXEC**
  - `in_ready` = 0.
  - At the end of the cycle, push one entry {err, zero, carry, data} into the FIFO.
  - Update `acc` (except on error, below).
  - Return to IDLE.

Result entry rules:
- **Data:** data = `alu_out`.
- **Carry/borrow:**
  - carry = `alu_carry` for ADD.
  - carry = (`alu_a` < `alu_b`) for SUB (borrow, computed locally).
  - carry = 0 for all other opcodes.
- **Zero:** zero = (data == 0).
- **Error:** DIV with `alu_b` == 0 forces data = 8'hFF, err = 1, zero = 0, carry = 0.
  - `acc` keeps its value.
  - Otherwise err = 0 and `acc` ← data.

FIFO:
- Show-ahead: head entry is always on the `res_*` outputs; `res_valid` = (count != 0).
- Pop on `res_valid && res_ready`.
- Push and pop on the same edge leave the count unchanged; the popped entry is the older one.
- Results appear strictly in issue order.
- A slot is always reserved before accept, so an EXEC push never overflows. The gating is `in_ready` low when count == `DEPTH`.
- `res_ready` while empty has no effect.

Other rules:
- `alu_a`/`alu_b`/`alu_op` hold their last values while in IDLE.
- `in_a`/`in_b`/`in_op` are ignored except on the accept edge.
- The accumulator update and the operand capture never collide: accept is only possible from IDLE, one cycle after the update.

## Timing
Reset (`rst_n` low, asynchronous) clears:
- state → IDLE.
- `alu_a`, `alu_b`, `alu_op`, `acc` → 0.
- FIFO count → 0, so `res_valid`, `res_data`, `res_carry`, `res_zero`, `res_err` → 0.
- `in_ready` → 1.

Reset during EXEC discards the in-flight op: no push, `acc` unchanged from its reset value 0.

Latency and throughput:
- Accept at edge T0; ALU operands are valid in the cycle after T0.
- The FIFO push is at edge T1 = T0+1, so `res_valid` is high after T1 if the FIFO was empty.
- Next accept is earliest at T2.
- Throughput is one op per 2 cycles.

Backpressure:
- With `res_ready` held low, `DEPTH` ops are accepted.
- `in_ready` drops after the `DEPTH`-th push.
- `in_ready` reasserts the cycle after the first pop.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → all outputs 0, `in_ready`=1, `res_valid`=0; release → first op accepted on the next edge.
- **ADD:** ADD a=F0 b=20, `res_ready`=1 → `res_valid` one cycle after accept edge +1; data 10, carry 1, zero 0, err 0, `acc`=10.
- **SUB, then chained ADD:**
  - SUB a=05 b=07 → data FE, carry 1.
  - Then ADD `in_use_acc`=1 b=02 → `alu_a`=FE, data 00, carry 1, zero 1.
- **Divide by zero:**
  - DIV a=12 b=00 → data FF, err 1, zero 0, `acc` unchanged (previous 00).
  - Then DIV a=12 b=03 → data 06, err 0, `acc`=06.
- **Backpressure, `DEPTH`=2, `res_ready`=0:**
  - Issue XOR(0F,FF), AND(0F,3C), OR(01,02).
  - Two are accepted; `in_ready`=0 with OR pending.
  - Pulse `res_ready` → F0 pops, OR is accepted; drain order is F0, 0C, 03.
- **Reset mid-EXEC:** accept MUL 03×05, drop `rst_n` during EXEC → no result ever appears; `acc`=0.
